// File: rtl/icache_refill_ctrl.sv
// Purpose: sequences I-cache line refills from memory and defers branch flushes until the stall clears.
// Latency: STALL rises in the miss cycle; the refill takes 2 + WORDS_PER_LINE*(1+L) stalled cycles.
// Backpressure: one memory read is outstanding at a time; WAIT holds until i_mem_valid.
module icache_refill_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_fetch_en,
  input  logic [ADDR_W-1:0]   i_pc,
  input  logic                i_hit,
  input  logic                i_branch_valid,
  output logic                o_mem_rden,
  output logic [ADDR_W-1:0]   o_mem_addr,
  input  logic [31:0]         i_mem_rdata,
  input  logic                i_mem_valid,
  output logic                o_line_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0] o_line_word,
  output logic [31:0]         o_line_data,
  output logic                o_tag_we,
  output logic                o_stall,
  output logic                o_flush
);

  localparam int OFF = $clog2(WORDS_PER_LINE) + 2;
  localparam int CW  = OFF - 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_UPDATE} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CW-1:0]       r_cnt;
  logic [ADDR_W-OFF-1:0] r_base;
  logic                r_pend;

  logic w_miss;
  logic w_flush_req;
  logic w_start;
  logic w_last;
  logic w_unused_pc_lo;

  // A pending branch counts as a flush request; a flush always beats a new refill.
  assign w_miss         = i_fetch_en & ~i_hit;
  assign w_flush_req    = i_branch_valid | r_pend;
  assign w_start        = (r_state == S_IDLE) & w_miss & ~w_flush_req;
  assign w_last         = (r_cnt == CW'(WORDS_PER_LINE - 1));
  // Line-offset bits of the PC never reach the base register.
  assign w_unused_pc_lo = ^i_pc[OFF-1:0];

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one REQ/WAIT pair per word, then a single UPDATE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_next_state = S_REQ;
      S_REQ:    w_next_state = S_WAIT;
      S_WAIT:   if (i_mem_valid) w_next_state = w_last ? S_UPDATE : S_REQ;
      S_UPDATE: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output decode; strobes are single-cycle by construction of the state sequence.
  always_comb begin
    o_mem_rden  = 1'b0;
    o_line_we   = 1'b0;
    o_line_data = 32'd0;
    o_tag_we    = 1'b0;
    o_stall     = 1'b0;
    o_flush     = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_flush = w_flush_req;
        o_stall = w_miss & ~w_flush_req;
      end
      S_REQ: begin
        o_stall    = 1'b1;
        o_mem_rden = 1'b1;
      end
      S_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_valid) begin
          o_line_we   = 1'b1;
          o_line_data = i_mem_rdata;
        end
      end
      S_UPDATE: begin
        o_stall  = 1'b1;
        o_tag_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_mem_addr  = {r_base, r_cnt, 2'b00};
  assign o_line_word = r_cnt;

  // Refill datapath: line base captured at miss time, word counter advances per returned word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_base <= '0;
    end else if (w_start) begin
      r_cnt  <= '0;
      r_base <= i_pc[ADDR_W-1:OFF];
    end else if ((r_state == S_WAIT) && i_mem_valid && !w_last) begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  // Branch held during a refill; released as a flush on the first IDLE cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (w_flush_req) r_pend <= 1'b0;
    end else if (i_branch_valid) begin
      r_pend <= 1'b1;
    end
  end

endmodule
